// File: rtl/gate_vec_pkg.sv
// gate_vec_pkg: shared types and helpers for the gate vector sequencer.
//   gv_state_e  - sequencer FSM states
//   FN_*        - GATE_FN codes selecting the expected-value reduction
//   gate_expect - reduces the low n bits of a vector with the selected gate
package gate_vec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } gv_state_e;

    localparam logic [2:0] FN_AND  = 3'd0;
    localparam logic [2:0] FN_OR   = 3'd1;
    localparam logic [2:0] FN_NAND = 3'd2;
    localparam logic [2:0] FN_NOR  = 3'd3;
    localparam logic [2:0] FN_XOR  = 3'd4;
    localparam logic [2:0] FN_XNOR = 3'd5;

    localparam int unsigned MAX_N_IN = 8;

    // Only the low n bits take part; upper bits of vec are ignored.
    function automatic logic gate_expect(input logic [2:0]          fn,
                                         input logic [MAX_N_IN-1:0] vec,
                                         input int unsigned         n);
        logic and_r;
        logic or_r;
        logic xor_r;
        logic res;
        and_r = 1'b1;
        or_r  = 1'b0;
        xor_r = 1'b0;
        for (int unsigned i = 0; i < MAX_N_IN; i++) begin
            if (i < n) begin
                and_r = and_r & vec[i];
                or_r  = or_r  | vec[i];
                xor_r = xor_r ^ vec[i];
            end
        end
        case (fn)
            FN_AND:  res = and_r;
            FN_OR:   res = or_r;
            FN_NAND: res = ~and_r;
            FN_NOR:  res = ~or_r;
            FN_XOR:  res = xor_r;
            FN_XNOR: res = ~xor_r;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/gate_vec_hold_timer.sv
// gate_vec_hold_timer: counts the clocks a vector has been held.
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - clear the count to 0 (wins over en)
//   en        - advance the count by one
//   expire    - high while the count equals HOLD_CYCLES-1
// The count stops at HOLD_CYCLES-1 so it can never wrap.
module gate_vec_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned           CNT_W = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CNT_W-1:0]      LAST  = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d;

    assign expire = (hold_cnt_q == LAST);

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (clr) begin
            hold_cnt_d = '0;
        end else if (en && !expire) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule

// File: rtl/gate_vector_sequencer.sv
// gate_vector_sequencer: drives every N_IN-bit vector, in ascending order,
// into a logic-gate DUT, holding each for HOLD_CYCLES clocks and then
// spending one SAMPLE clock on it.
//   clk, rst   - clock, asynchronous active-high reset
//   start      - run request, honoured only in IDLE or DONE
//   y          - DUT output under test
//   vec_out    - vector applied to the DUT (MSB = A, LSB = B for N_IN=2)
//   vec_valid  - vec_out is being applied (DRIVE/SAMPLE)
//   exp_y      - expected DUT output for vec_out (GATE_FN reduction)
//   busy       - run in progress
//   done       - run finished; held until start or rst
//   mismatch   - one-clock pulse in SAMPLE when y differs from exp_y
//   err_cnt    - saturating mismatch count for the current run
// Build option: define GATE_VEC_SELF_CHECK_EN to enable the y/exp_y compare;
// otherwise mismatch and err_cnt are tied low and y is ignored.
module gate_vector_sequencer
    import gate_vec_pkg::*;
#(
    parameter int unsigned N_IN        = 2,
    parameter int unsigned HOLD_CYCLES = 100,
    parameter int unsigned GATE_FN     = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            y,
    output logic [N_IN-1:0] vec_out,
    output logic            vec_valid,
    output logic            exp_y,
    output logic            busy,
    output logic            done,
    output logic            mismatch,
    output logic [N_IN:0]   err_cnt
);

    localparam logic [2:0] FN_SEL = 3'(GATE_FN);

    gv_state_e         state_q;
    gv_state_e         state_d;
    logic [N_IN-1:0]   vec_q;
    logic [N_IN-1:0]   vec_d;
    logic              tmr_clr;
    logic              tmr_en;
    logic              tmr_expire;
    logic [MAX_N_IN-1:0] vec_ext;

    gate_vec_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .expire(tmr_expire)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    vec_d   = '0;
                    tmr_clr = 1'b1;
                end
            end
            DRIVE: begin
                tmr_en = 1'b1;
                if (tmr_expire) begin
                    state_d = SAMPLE;
                    tmr_clr = 1'b1;
                end
            end
            SAMPLE: begin
                // start is not looked at here, so a start coinciding with
                // DONE entry is dropped.
                if (vec_q == '1) begin
                    state_d = DONE;
                end else begin
                    state_d = DRIVE;
                    vec_d   = vec_q + N_IN'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
        end
    end

    always_comb begin
        vec_ext            = '0;
        vec_ext[N_IN-1:0]  = vec_q;
    end

    assign vec_out   = vec_q;
    assign exp_y     = gate_expect(FN_SEL, vec_ext, N_IN);
    assign busy      = (state_q == DRIVE) || (state_q == SAMPLE);
    assign vec_valid = busy;
    assign done      = (state_q == DONE);

`ifdef GATE_VEC_SELF_CHECK_EN
    logic          y_q;
    logic          start_accept;
    logic          mismatch_w;
    logic [N_IN:0] err_q;
    logic [N_IN:0] err_d;

    assign start_accept = start && ((state_q == IDLE) || (state_q == DONE));
    // y_q in SAMPLE holds y from the last DRIVE clock, i.e. HOLD_CYCLES
    // clocks after the vector was first applied.
    assign mismatch_w   = (state_q == SAMPLE) && (y_q != exp_y);

    always_comb begin
        err_d = err_q;
        if (start_accept) begin
            err_d = '0;
        end else if (mismatch_w && (err_q != '1)) begin
            err_d = err_q + (N_IN + 1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q   <= 1'b0;
            err_q <= '0;
        end else begin
            y_q   <= y;
            err_q <= err_d;
        end
    end

    assign mismatch = mismatch_w;
    assign err_cnt  = err_q;
`else
    logic unused_y;
    assign unused_y = y;
    assign mismatch = 1'b0;
    assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Bench for gate_vector_sequencer: three instances (NOR N=2/H=4, AND N=2/H=1,
// XOR N=3/H=2). Stimulus pushes expected per-vector segments and run-done
// records into per-instance queues; a negedge monitor rebuilds the same
// records from the DUT outputs and compares them in order.
module tb_gate_vector_sequencer;

`ifdef GATE_VEC_SELF_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam int KIND_SEG  = 0;
    localparam int KIND_DONE = 1;

    typedef struct {
        int kind;
        int a;   // seg: vector   done: clocks busy
        int b;   // seg: length   done: err_cnt
        int c;   // seg: exp_y
        int d;   // seg: mismatch pulses
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic y_fault = 1'b0;
    logic y0, y1, y2;

    logic [1:0] vec0;  logic vv0, ey0, bz0, dn0, mm0;  logic [2:0] err0;
    logic [1:0] vec1;  logic vv1, ey1, bz1, dn1, mm1;  logic [2:0] err1;
    logic [2:0] vec2;  logic vv2, ey2, bz2, dn2, mm2;  logic [3:0] err2;

    assign y0 = y_fault ? 1'b0 : ~|vec0;
    assign y1 = &vec1;
    assign y2 = ^vec2;

    always #5 clk = ~clk;

    gate_vector_sequencer #(.N_IN(2), .HOLD_CYCLES(4), .GATE_FN(3)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .y(y0), .vec_out(vec0),
        .vec_valid(vv0), .exp_y(ey0), .busy(bz0), .done(dn0),
        .mismatch(mm0), .err_cnt(err0));

    gate_vector_sequencer #(.N_IN(2), .HOLD_CYCLES(1), .GATE_FN(0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .y(y1), .vec_out(vec1),
        .vec_valid(vv1), .exp_y(ey1), .busy(bz1), .done(dn1),
        .mismatch(mm1), .err_cnt(err1));

    gate_vector_sequencer #(.N_IN(3), .HOLD_CYCLES(2), .GATE_FN(4)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .y(y2), .vec_out(vec2),
        .vec_valid(vv2), .exp_y(ey2), .busy(bz2), .done(dn2),
        .mismatch(mm2), .err_cnt(err2));

    // Hand-computed expected outputs per vector.
    int nor_tab [4] = '{1, 0, 0, 0};
    int and_tab [4] = '{0, 0, 0, 1};
    int par_tab [8] = '{0, 1, 1, 0, 1, 0, 0, 1};

    int n_chk  = 0;
    int n_fail = 0;

    rec_t q0[$];
    rec_t q1[$];
    rec_t q2[$];

    int cur_vec [3];
    int cur_len [3] = '{0, 0, 0};
    int cur_exp [3];
    int cur_mm  [3];
    int run_cyc [3] = '{0, 0, 0};
    bit prev_dn [3] = '{0, 0, 0};

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input int id, input rec_t r);
        case (id)
            0:       q0.push_back(r);
            1:       q1.push_back(r);
            default: q2.push_back(r);
        endcase
    endtask

    task automatic emit(input int id, input rec_t got);
        rec_t e;
        bit   have;
        have = 1'b0;
        e    = '{0, 0, 0, 0, 0};
        case (id)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        n_chk++;
        if (!have) begin
            n_fail++;
            $display("FAIL dut%0d_unexpected: got kind=%0d a=%0d b=%0d c=%0d d=%0d, expected no record (t=%0t)",
                     id, got.kind, got.a, got.b, got.c, got.d, $time);
        end else if (got.kind != e.kind || got.a != e.a || got.b != e.b ||
                     got.c != e.c || got.d != e.d) begin
            n_fail++;
            $display("FAIL dut%0d_%s: got a=%0d b=%0d c=%0d d=%0d, expected kind=%0d a=%0d b=%0d c=%0d d=%0d (t=%0t)",
                     id, (got.kind == KIND_SEG) ? "seg" : "done", got.a, got.b, got.c, got.d,
                     e.kind, e.a, e.b, e.c, e.d, $time);
        end
    endtask

    task automatic flush(input int id);
        emit(id, '{KIND_SEG, cur_vec[id], cur_len[id], cur_exp[id], cur_mm[id]});
        cur_len[id] = 0;
    endtask

    task automatic observe(input int id, input logic vv, input int vec, input logic ey,
                           input logic mm, input logic bz, input logic dn, input int err);
        if (vv) begin
            if (cur_len[id] > 0 && vec == cur_vec[id]) begin
                cur_len[id]++;
                cur_mm[id] += mm ? 1 : 0;
            end else begin
                if (cur_len[id] > 0) flush(id);
                cur_vec[id] = vec;
                cur_len[id] = 1;
                cur_exp[id] = ey ? 1 : 0;
                cur_mm[id]  = mm ? 1 : 0;
            end
        end else if (cur_len[id] > 0) begin
            flush(id);
        end
        if (rst) run_cyc[id] = 0;
        else if (bz) run_cyc[id]++;
        if (dn && !prev_dn[id]) begin
            emit(id, '{KIND_DONE, run_cyc[id], err, 0, 0});
            run_cyc[id] = 0;
        end
        prev_dn[id] = dn;
    endtask

    always @(negedge clk) begin
        observe(0, vv0, int'(vec0), ey0, mm0, bz0, dn0, int'(err0));
        observe(1, vv1, int'(vec1), ey1, mm1, bz1, dn1, int'(err1));
        observe(2, vv2, int'(vec2), ey2, mm2, bz2, dn2, int'(err2));
    end

    function automatic int tab(input int id, input int v);
        case (id)
            0:       return nor_tab[v];
            1:       return and_tab[v];
            default: return par_tab[v];
        endcase
    endfunction

    // Expected records for a whole run; with fault set y is stuck at 0, so
    // only vectors whose expected value is 1 can mismatch.
    task automatic push_run(input int id, input int nv, input int len, input bit fault);
        int errs;
        int mm;
        errs = 0;
        for (int v = 0; v < nv; v++) begin
            mm = (fault && CHK && tab(id, v) != 0) ? 1 : 0;
            errs += mm;
            push(id, '{KIND_SEG, v, len, tab(id, v), mm});
        end
        // Busy clocks = nv*len, so done appears on clock nv*len+1 counting
        // the start-acceptance edge as clock 1.
        push(id, '{KIND_DONE, nv * len, errs, 0, 0});
    endtask

    task automatic pulse_start(input int id);
        @(negedge clk);
        case (id)
            0:       start0 = 1'b1;
            1:       start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    function automatic logic dn_of(input int id);
        case (id)
            0:       return dn0;
            1:       return dn1;
            default: return dn2;
        endcase
    endfunction

    task automatic wait_done(input int id, input int budget);
        int k;
        k = 0;
        while (!dn_of(id) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("dut%0d_done_within_budget", id), dn_of(id) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // Power-on reset, then a reset pulse while idle.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_idle_vec_out", int'(vec0), 0);
        chk("rst_idle_vec_valid", int'(vv0), 0);
        chk("rst_idle_busy", int'(bz0), 0);
        chk("rst_idle_done", int'(dn0), 0);
        chk("rst_idle_mismatch", int'(mm0), 0);
        chk("rst_idle_err_cnt", int'(err0), 0);
        #1 rst = 1'b0;

        // No start for 50 clocks: nothing moves.
        repeat (50) @(negedge clk);
        chk("idle50_busy", int'(bz0), 0);
        chk("idle50_done", int'(dn0), 0);
        chk("idle50_vec_out", int'(vec0), 0);

        // Clean NOR run.
        push_run(0, 4, 5, 1'b0);
        pulse_start(0);
        wait_done(0, 60);

        // Fault run from DONE with y stuck at 0.
        y_fault = 1'b1;
        push_run(0, 4, 5, 1'b1);
        pulse_start(0);
        wait_done(0, 60);
        repeat (5) @(negedge clk);
        chk("done_held", int'(dn0), 1);
        chk("done_err_cnt", int'(err0), CHK ? 1 : 0);

        // Restart from DONE, plus a start pulse on clock 7 that must be ignored.
        y_fault = 1'b0;
        push_run(0, 4, 5, 1'b0);
        pulse_start(0);
        @(negedge clk);
        chk("restart_err_cnt", int'(err0), 0);
        chk("restart_vec_out", int'(vec0), 0);
        chk("restart_busy", int'(bz0), 1);
        chk("restart_done", int'(dn0), 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        wait_done(0, 60);

        // HOLD_CYCLES=1 AND instance: two clocks per vector.
        push_run(1, 4, 2, 1'b0);
        pulse_start(1);
        wait_done(1, 40);

        // N_IN=3 XOR instance: eight vectors, parity expected.
        push_run(2, 8, 3, 1'b0);
        pulse_start(2);
        wait_done(2, 60);

        // Reset during vector 2: two clocks of vector 2 are observed first.
        push(0, '{KIND_SEG, 0, 5, 1, 0});
        push(0, '{KIND_SEG, 1, 5, 0, 0});
        push(0, '{KIND_SEG, 2, 2, 0, 0});
        pulse_start(0);
        repeat (12) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_run_vec_out", int'(vec0), 0);
        chk("rst_run_busy", int'(bz0), 0);
        chk("rst_run_vec_valid", int'(vv0), 0);
        chk("rst_run_done", int'(dn0), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_run_no_resume", int'(bz0), 0);

        push_run(0, 4, 5, 1'b0);
        pulse_start(0);
        wait_done(0, 60);

        repeat (3) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
